// File: rtl/commit_pkg.sv
// Shared definitions for the in-order commit controller: entry layout, types, FSM codes.
package commit_pkg;

  localparam int DEPTH   = 32;
  localparam int PTR_W   = 5;
  localparam int OCC_W   = PTR_W + 1;
  localparam int ENTRY_W = 42;

  // Entry field positions inside a regfiletmp word
  localparam int RD_MSB     = 41;
  localparam int RD_LSB     = 37;
  localparam int PC_MSB     = 36;
  localparam int PC_LSB     = 5;
  localparam int TYPE_MSB   = 4;
  localparam int TYPE_LSB   = 3;
  localparam int SPEC_DATA  = 2;
  localparam int SPEC_VALID = 1;
  localparam int VALID      = 0;

  localparam logic [1:0] TYPE_ALU = 2'b00;
  localparam logic [1:0] TYPE_LD  = 2'b01;
  localparam logic [1:0] TYPE_ST  = 2'b10;
  localparam logic [1:0] TYPE_BR  = 2'b11;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  typedef logic [ENTRY_W-1:0] entry_t;

  // A freshly dispatched entry is valid but not yet speculatively resolved.
  function automatic entry_t pack_dispatch(input logic [4:0]  rd,
                                           input logic [31:0] pc,
                                           input logic [1:0]  typ);
    return {rd, pc, typ, 1'b0, 1'b0, 1'b1};
  endfunction

endpackage

// File: rtl/commit_unit_wrap_ptr.sv
// Wrapping ring-buffer pointer with increment and synchronous clear (clear wins).
module wrap_ptr
  import commit_pkg::*;
#(
  parameter int W = PTR_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] ptr
);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     ptr <= '0;
    else if (clear) ptr <= '0;
    else if (inc)   ptr <= ptr + 1'b1;
  end

endmodule

// File: rtl/commit_unit.sv
// In-order allocate/retire controller for the 32-entry regfiletmp window.
// Optional COMMIT_STATS_EN adds free-running commit/flush counters.
module commit_unit
  import commit_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               disp_valid,
  input  logic [4:0]         disp_rd,
  input  logic [31:0]        disp_pc,
  input  logic [1:0]         disp_type,
  output logic               disp_ready,
  output logic               New_entry,
  output logic [PTR_W-1:0]   Waddr,
  output logic [ENTRY_W-1:0] Data_In,
  output logic [PTR_W-1:0]   Rd_Addr1,
  input  logic [ENTRY_W-1:0] Data_out1,
  output logic               commit_valid,
  output logic [4:0]         commit_rd,
  output logic [31:0]        commit_pc,
  output logic [1:0]         commit_type,
  output logic               flush,
  output logic [31:0]        flush_pc,
  output logic [OCC_W-1:0]   occupancy
`ifdef COMMIT_STATS_EN
  ,
  output logic [31:0]        stat_commits,
  output logic [31:0]        stat_flushes
`endif
);

  logic [0:0]       state;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [OCC_W-1:0] occ;
  logic             accept;
  logic             head_done;
  logic             retire;
  logic             mispredict;

  // A retire in the same cycle never frees room for a dispatch; readiness looks only at current occupancy.
  assign disp_ready = (state == ST_RUN) && (occ < OCC_W'(DEPTH));
  assign accept     = disp_valid && disp_ready;
  assign head_done  = (occ != '0) && Data_out1[VALID] && Data_out1[SPEC_VALID];
  assign retire     = (state == ST_RUN) && head_done;
  assign mispredict = retire && (Data_out1[TYPE_MSB:TYPE_LSB] == TYPE_BR) && Data_out1[SPEC_DATA];

  assign New_entry  = accept;
  assign Waddr      = tail;
  assign Data_In    = pack_dispatch(disp_rd, disp_pc, disp_type);
  assign Rd_Addr1   = head;
  assign occupancy  = occ;

  wrap_ptr #(.W(PTR_W)) u_head (
    .clock (clock),
    .reset (reset),
    .inc   (retire),
    .clear (mispredict),
    .ptr   (head)
  );

  // A dispatch landing on the mispredict edge is dropped by the clear.
  wrap_ptr #(.W(PTR_W)) u_tail (
    .clock (clock),
    .reset (reset),
    .inc   (accept),
    .clear (mispredict),
    .ptr   (tail)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                  occ <= '0;
    else if (mispredict)         occ <= '0;
    else if (accept && !retire)  occ <= occ + 1'b1;
    else if (retire && !accept)  occ <= occ - 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                  state <= ST_RUN;
    else if (state == ST_FLUSH)  state <= ST_RUN;
    else if (mispredict)         state <= ST_FLUSH;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      commit_valid <= 1'b0;
      commit_rd    <= '0;
      commit_pc    <= '0;
      commit_type  <= '0;
      flush        <= 1'b0;
      flush_pc     <= '0;
    end else begin
      commit_valid <= retire;
      flush        <= mispredict;
      if (retire) begin
        commit_rd   <= Data_out1[RD_MSB:RD_LSB];
        commit_pc   <= Data_out1[PC_MSB:PC_LSB];
        commit_type <= Data_out1[TYPE_MSB:TYPE_LSB];
      end
      if (mispredict) flush_pc <= Data_out1[PC_MSB:PC_LSB];
    end
  end

`ifdef COMMIT_STATS_EN
  // Counted on the same edge that raises commit_valid / flush, so they move together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_commits <= '0;
      stat_flushes <= '0;
    end else begin
      if (retire)     stat_commits <= stat_commits + 32'd1;
      if (mispredict) stat_flushes <= stat_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_commit_unit.sv
// Self-checking bench for commit_unit; a queue scoreboard holds the expected commits and flushes.
module tb_commit_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        disp_valid;
  logic [4:0]  disp_rd;
  logic [31:0] disp_pc;
  logic [1:0]  disp_type;
  logic        disp_ready;
  logic        New_entry;
  logic [4:0]  Waddr;
  logic [41:0] Data_In;
  logic [4:0]  Rd_Addr1;
  logic [41:0] Data_out1;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_pc;
  logic [1:0]  commit_type;
  logic        flush;
  logic [31:0] flush_pc;
  logic [5:0]  occupancy;
`ifdef COMMIT_STATS_EN
  logic [31:0] stat_commits;
  logic [31:0] stat_flushes;
`endif

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [1:0]  typ;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] flush_q[$];
  logic [41:0] slot[32];
  logic [4:0]  b_head;
  logic [4:0]  b_tail;
  int          b_occ;
  int          total;
  int          bad;

  always #5 clock = ~clock;

  commit_unit dut (
    .clock        (clock),
    .reset        (reset),
    .disp_valid   (disp_valid),
    .disp_rd      (disp_rd),
    .disp_pc      (disp_pc),
    .disp_type    (disp_type),
    .disp_ready   (disp_ready),
    .New_entry    (New_entry),
    .Waddr        (Waddr),
    .Data_In      (Data_In),
    .Rd_Addr1     (Rd_Addr1),
    .Data_out1    (Data_out1),
    .commit_valid (commit_valid),
    .commit_rd    (commit_rd),
    .commit_pc    (commit_pc),
    .commit_type  (commit_type),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .occupancy    (occupancy)
`ifdef COMMIT_STATS_EN
    ,
    .stat_commits (stat_commits),
    .stat_flushes (stat_flushes)
`endif
  );

  // Advance one clock; any commit/flush pulse is matched against the scoreboard.
  task automatic tick();
    exp_t        e;
    logic [31:0] fp;
    @(posedge clock);
    #1;
    if (commit_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL commit_spurious got rd=%0d pc=%h expected no commit", commit_rd, commit_pc);
      end else begin
        e = exp_q.pop_front();
        if ({commit_rd, commit_pc, commit_type} !== {e.rd, e.pc, e.typ}) begin
          bad++;
          $display("FAIL commit_data got rd=%0d pc=%h type=%0d expected rd=%0d pc=%h type=%0d",
                   commit_rd, commit_pc, commit_type, e.rd, e.pc, e.typ);
        end
      end
    end
    if (flush === 1'b1) begin
      total++;
      if (flush_q.size() == 0) begin
        bad++;
        $display("FAIL flush_spurious got flush_pc=%h expected no flush", flush_pc);
      end else begin
        fp = flush_q.pop_front();
        if (flush_pc !== fp) begin
          bad++;
          $display("FAIL flush_pc got %h expected %h", flush_pc, fp);
        end
      end
    end
  endtask

  // One RUN-state cycle with optional dispatch and optional completed head.
  task automatic cyc(input bit do_disp, input bit do_ret, input logic [4:0] rd,
                     input logic [31:0] pc, input logic [1:0] typ, input string tag);
    bit          exp_acc;
    bit          exp_ret;
    logic [41:0] d;
    exp_t        e;
    exp_acc    = do_disp && (b_occ < 32);
    exp_ret    = do_ret && (b_occ != 0);
    d          = {rd, pc, typ, 3'b001};
    disp_valid = do_disp;
    disp_rd    = rd;
    disp_pc    = pc;
    disp_type  = typ;
    Data_out1  = do_ret ? {slot[b_head][41:2], 2'b11} : 42'd0;
    #1;
    total++;
    if (New_entry !== exp_acc || disp_ready !== (b_occ < 32) || Rd_Addr1 !== b_head) begin
      bad++;
      $display("FAIL %s_pre got new=%b ready=%b raddr=%0d expected new=%b ready=%b raddr=%0d",
               tag, New_entry, disp_ready, Rd_Addr1, exp_acc, (b_occ < 32), b_head);
    end
    if (exp_acc) begin
      total++;
      if (Waddr !== b_tail || Data_In !== d) begin
        bad++;
        $display("FAIL %s_write got waddr=%0d data=%h expected waddr=%0d data=%h",
                 tag, Waddr, Data_In, b_tail, d);
      end
    end
    if (exp_ret) begin
      e.rd  = slot[b_head][41:37];
      e.pc  = slot[b_head][36:5];
      e.typ = slot[b_head][4:3];
      exp_q.push_back(e);
    end
    if (exp_acc) slot[b_tail] = d;
    tick();
    disp_valid = 1'b0;
    Data_out1  = 42'd0;
    if (exp_acc) b_tail = b_tail + 5'd1;
    if (exp_ret) b_head = b_head + 5'd1;
    b_occ = b_occ + (exp_acc ? 1 : 0) - (exp_ret ? 1 : 0);
    total++;
    if (occupancy !== 6'(b_occ) || Waddr !== b_tail || Rd_Addr1 !== b_head ||
        disp_ready !== (b_occ < 32) || exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_post got occ=%0d waddr=%0d raddr=%0d ready=%b pending=%0d expected occ=%0d waddr=%0d raddr=%0d ready=%b pending=0",
               tag, occupancy, Waddr, Rd_Addr1, disp_ready, exp_q.size(), b_occ, b_tail, b_head, (b_occ < 32));
    end
  endtask

  task automatic model_clear();
    b_head = '0;
    b_tail = '0;
    b_occ  = 0;
  endtask

  task automatic test_reset();
    disp_valid = 1'b0;
    disp_rd    = '0;
    disp_pc    = '0;
    disp_type  = '0;
    Data_out1  = '0;
    #2 reset = 1'b0;
    #1;
    total++;
    if (occupancy !== 6'd0 || commit_valid !== 1'b0 || flush !== 1'b0 || Rd_Addr1 !== 5'd0 || Waddr !== 5'd0) begin
      bad++;
      $display("FAIL reset_state got occ=%0d cv=%b fl=%b raddr=%0d waddr=%0d expected all 0",
               occupancy, commit_valid, flush, Rd_Addr1, Waddr);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    total++;
    if (disp_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got %b expected 1", disp_ready);
    end
    model_clear();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 5'(i + 20), 32'h80 + 32'(i), 2'b00, "rst_fill");
    cyc(1'b0, 1'b1, '0, '0, '0, "rst_ret");
    reset = 1'b0;
    #1;
    total++;
    if (commit_valid !== 1'b0 || occupancy !== 6'd0 || Rd_Addr1 !== 5'd0 || Waddr !== 5'd0 || flush !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid got cv=%b occ=%0d raddr=%0d waddr=%0d fl=%b expected all 0",
               commit_valid, occupancy, Rd_Addr1, Waddr, flush);
    end
    @(negedge clock);
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_dispatch_full();
    for (int i = 0; i < 32; i++)
      cyc(1'b1, 1'b0, 5'(i), 32'h100 + 32'(4 * i), 2'(i % 4), "fill");
    total++;
    if (occupancy !== 6'd32 || disp_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_state got occ=%0d ready=%b expected occ=32 ready=0", occupancy, disp_ready);
    end
    cyc(1'b1, 1'b0, 5'd31, 32'hdead, 2'b00, "overfill");
  endtask

  task automatic test_retire();
    slot[b_head][41:37] = 5'd5;
    cyc(1'b0, 1'b1, '0, '0, '0, "retire");
    total++;
    if (commit_valid !== 1'b1 || commit_rd !== 5'd5 || commit_pc !== 32'h100 || commit_type !== 2'b00) begin
      bad++;
      $display("FAIL retire_out got cv=%b rd=%0d pc=%h type=%0d expected cv=1 rd=5 pc=100 type=0",
               commit_valid, commit_rd, commit_pc, commit_type);
    end
    cyc(1'b0, 1'b0, '0, '0, '0, "idle");
    total++;
    if (commit_valid !== 1'b0) begin
      bad++;
      $display("FAIL retire_pulse got cv=%b expected 0", commit_valid);
    end
  endtask

  task automatic test_back_to_back();
    cyc(1'b1, 1'b0, 5'd7, 32'h500, 2'b01, "refill");
    cyc(1'b1, 1'b1, 5'd8, 32'h504, 2'b10, "full_both");
    for (int i = 0; i < 21; i++) cyc(1'b0, 1'b1, '0, '0, '0, "drain");
    cyc(1'b1, 1'b1, 5'd9, 32'h508, 2'b00, "both10");
    total++;
    if (occupancy !== 6'd10) begin
      bad++;
      $display("FAIL both_occ got %0d expected 10", occupancy);
    end
  endtask

  task automatic test_mispredict();
    exp_t e;
    slot[b_head] = {5'd9, 32'h200, 2'b11, 1'b1, 1'b1, 1'b1};
    e.rd  = 5'd9;
    e.pc  = 32'h200;
    e.typ = 2'b11;
    exp_q.push_back(e);
    flush_q.push_back(32'h200);
    Data_out1  = slot[b_head];
    disp_valid = 1'b1;
    disp_rd    = 5'd3;
    disp_pc    = 32'h900;
    disp_type  = 2'b00;
    #1;
    total++;
    if (New_entry !== 1'b1) begin
      bad++;
      $display("FAIL mp_concurrent got new=%b expected 1", New_entry);
    end
    tick();
    Data_out1 = '0;
    total++;
    if (commit_valid !== 1'b1 || flush !== 1'b1 || occupancy !== 6'd0 || Rd_Addr1 !== 5'd0 ||
        Waddr !== 5'd0 || disp_ready !== 1'b0 || New_entry !== 1'b0 || exp_q.size() != 0 || flush_q.size() != 0) begin
      bad++;
      $display("FAIL mp_flush got cv=%b fl=%b occ=%0d raddr=%0d waddr=%0d ready=%b new=%b expected cv=1 fl=1 occ=0 raddr=0 waddr=0 ready=0 new=0",
               commit_valid, flush, occupancy, Rd_Addr1, Waddr, disp_ready, New_entry);
    end
    tick();
    disp_valid = 1'b0;
    total++;
    if (flush !== 1'b0 || disp_ready !== 1'b1 || occupancy !== 6'd0 || Waddr !== 5'd0) begin
      bad++;
      $display("FAIL mp_recover got fl=%b ready=%b occ=%0d waddr=%0d expected fl=0 ready=1 occ=0 waddr=0",
               flush, disp_ready, occupancy, Waddr);
    end
    model_clear();
`ifdef COMMIT_STATS_EN
    total++;
    if (stat_flushes !== 32'd1) begin
      bad++;
      $display("FAIL stat_flushes got %0d expected 1", stat_flushes);
    end
`endif
  endtask

  task automatic test_wrap();
    @(negedge clock);
    reset = 1'b0;
    #1 reset = 1'b1;
    model_clear();
    cyc(1'b1, 1'b0, 5'd0, 32'h3000, 2'b00, "wrap_first");
    for (int k = 0; k < 40; k++)
      cyc(1'b1, 1'b1, 5'(k + 1), 32'h3004 + 32'(4 * k), 2'(k % 4), "wrap_pair");
`ifdef COMMIT_STATS_EN
    total++;
    if (stat_commits !== 32'd40 || stat_flushes !== 32'd0) begin
      bad++;
      $display("FAIL stat_commits got commits=%0d flushes=%0d expected 40 and 0", stat_commits, stat_flushes);
    end
`endif
    cyc(1'b0, 1'b1, '0, '0, '0, "wrap_drain");
    cyc(1'b0, 1'b1, '0, '0, '0, "empty_head");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_clear();
    test_reset();
    test_dispatch_full();
    test_retire();
    test_back_to_back();
    test_mispredict();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
